// File: rtl/rr_stream_mux.sv
// N-channel stream multiplexer with a one-word registered output stage.
// Channels are granted round-robin or by a fixed index; output is valid/ready.
module rr_stream_mux #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SW-1:0]        fixed_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_sel
);

  logic [SW-1:0]    last;
  logic [SW-1:0]    rr_grant;
  logic             rr_found;
  logic [SW-1:0]    grant;
  logic             grant_valid;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  // Cyclic search from last+1; SW-bit addition wraps N-1 -> 0 because N is a power of two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rr_grant = last;
    rr_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_found && in_valid[last + SW'(k)]) begin
        rr_grant = last + SW'(k);
        rr_found = 1'b1;
      end
    end
  end

  assign grant       = mode ? fixed_sel : rr_grant;
  assign grant_valid = mode ? in_valid[fixed_sel] : rr_found;

  // The output register can take a new word when empty or when it drains this cycle.
  assign load_en = !out_valid || out_ready;
  assign accept  = load_en && grant_valid;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  assign sel_data = in_data[grant*WIDTH +: WIDTH];

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SW'(N - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant;
      last      <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux (WIDTH=8, N=4): fairness, backpressure,
// skip/wrap, fixed mode, async reset mid-stream and idle behaviour.
module tb_rr_stream_mux;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SW-1:0]      fixed_sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;

  int checks = 0;
  int errors = 0;

  rr_stream_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .fixed_sel (fixed_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [SW-1:0] s,
                           input logic [WIDTH-1:0] d);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out_sel"},   64'(out_sel),   64'(s));
    check({tag, ".out_data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = '0;
    mode      = 1'b0;
    fixed_sel = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check_out("reset", 1'b0, 2'd0, 8'h00);
    check("reset.last", 64'(dut.last), 64'd3);
    in_valid = 4'b1111;
    #1;
    check("reset.in_ready", 64'(in_ready), 64'b0001);
    #9;
    check_out("reset_held", 1'b0, 2'd0, 8'h00);

    // Fairness: 0,1,2,3,0 at one word per cycle
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("fair.first_ready", 64'(in_ready), 64'b0001);
    check("fair.not_yet_valid", 64'(out_valid), 64'd0);
    step(); check_out("fair0", 1'b1, 2'd0, 8'h11); check("fair0.rdy", 64'(in_ready), 64'b0010);
    step(); check_out("fair1", 1'b1, 2'd1, 8'h22); check("fair1.rdy", 64'(in_ready), 64'b0100);
    step(); check_out("fair2", 1'b1, 2'd2, 8'h33); check("fair2.rdy", 64'(in_ready), 64'b1000);
    step(); check_out("fair3", 1'b1, 2'd3, 8'h44); check("fair3.rdy", 64'(in_ready), 64'b0001);
    step(); check_out("fair4", 1'b1, 2'd0, 8'h11); check("fair4.rdy", 64'(in_ready), 64'b0010);

    // Backpressure: hold 0xA5 from channel 1 for 5 cycles
    in_valid = 4'b0010;
    in_data  = {8'h44, 8'h33, 8'hA5, 8'h11};
    step(); check_out("bp_load", 1'b1, 2'd1, 8'hA5);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    #1;
    check("bp.rdy_now", 64'(in_ready), 64'b0000);
    for (int c = 0; c < 5; c++) begin
      step();
      check_out("bp_hold", 1'b1, 2'd1, 8'hA5);
      check("bp_hold.rdy", 64'(in_ready), 64'b0000);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    #1;
    check("bp_drain.rdy", 64'(in_ready), 64'b0000);
    step(); check("bp_drained", 64'(out_valid), 64'd0);
    check("bp.last", 64'(dut.last), 64'd1);

    // Skip and wrap: last=1, only channels 0 and 3 valid -> 3 then 0
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1001;
    #1;
    check("wrap.rdy", 64'(in_ready), 64'b1000);
    step(); check_out("wrap3", 1'b1, 2'd3, 8'h44); check("wrap3.rdy", 64'(in_ready), 64'b0001);
    step(); check_out("wrap0", 1'b1, 2'd0, 8'h11); check("wrap0.rdy", 64'(in_ready), 64'b1000);
    in_valid = 4'b0000;
    step(); check("wrap_drain", 64'(out_valid), 64'd0);

    // Fixed mode: only channel 2 granted
    mode      = 1'b1;
    fixed_sel = 2'd2;
    in_valid  = 4'b1111;
    #1;
    check("fix.rdy", 64'(in_ready), 64'b0100);
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("fix", 1'b1, 2'd2, 8'h33);
      check("fix.rdy_loop", 64'(in_ready), 64'b0100);
    end
    in_valid = 4'b1011;
    #1;
    check("fix_ineligible.rdy", 64'(in_ready), 64'b0000);
    step(); check("fix_ineligible.drain", 64'(out_valid), 64'd0);
    check("fix.last", 64'(dut.last), 64'd2);
    mode     = 1'b0;
    in_valid = 4'b1111;
    #1;
    check("fix_to_rr.rdy", 64'(in_ready), 64'b1000);
    check("fix_to_rr.sel_held", 64'(out_sel), 64'd2);
    step(); check_out("fix_to_rr", 1'b1, 2'd3, 8'h44);

    // Mode change with a held word leaves that word untouched
    out_ready = 1'b0;
    mode      = 1'b1;
    fixed_sel = 2'd1;
    step(); check_out("mode_chg_hold", 1'b1, 2'd3, 8'h44);
    mode      = 1'b0;
    out_ready = 1'b1;
    step(); check_out("rr_resume", 1'b1, 2'd0, 8'h11);

    // Reset mid-stream discards the word without a clock edge
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 2'd0, 8'h00);
    check("async_rst.last", 64'(dut.last), 64'd3);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst.rdy", 64'(in_ready), 64'b0001);
    step(); check_out("post_rst", 1'b1, 2'd0, 8'h11);

    // Idle: no valid channels for 10 cycles
    in_valid = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle.out_valid", 64'(out_valid), 64'd0);
      check("idle.rdy", 64'(in_ready), 64'b0000);
    end
    check("idle.last", 64'(dut.last), 64'd0);
    in_valid = 4'b1111;
    #1;
    check("idle_resume.rdy", 64'(in_ready), 64'b0010);
    step(); check_out("idle_resume", 1'b1, 2'd1, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
